// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matmul_pkg
// Description : Shared definitions for the multi-matrix SRAM multiply engine.
//               Holds the FSM state encoding, header-field extract helpers and
//               the result reduction (saturate / truncate) function.
//               Helpers work on words up to MAX_DATA_W bits; callers
//               zero-extend into them and size-cast the result back.
// Revision    : 1.0 - initial release
// ============================================================================
package matmul_pkg;

  // Widest SRAM word the helpers support.
  localparam int MAX_DATA_W = 128;
  localparam int MAX_ACC_W  = 2 * MAX_DATA_W + 4;

  // FSM state encoding.
  localparam int         STATE_W      = 3;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_HDR_ADDR  = 3'd1;
  localparam logic [2:0] ST_HDR_LATCH = 3'd2;
  localparam logic [2:0] ST_CHECK     = 3'd3;
  localparam logic [2:0] ST_MAC       = 3'd4;
  localparam logic [2:0] ST_DRAIN     = 3'd5;

  // Upper half of a data_w-bit header word (word must be zero-extended).
  function automatic logic [MAX_DATA_W/2-1:0] hdr_hi(input logic [MAX_DATA_W-1:0] word,
                                                     input int data_w);
    logic [MAX_DATA_W-1:0] shifted;
    shifted = word >> (data_w / 2);
    return shifted[MAX_DATA_W/2-1:0];
  endfunction

  // Lower half of a data_w-bit header word.
  function automatic logic [MAX_DATA_W/2-1:0] hdr_lo(input logic [MAX_DATA_W-1:0] word,
                                                     input int data_w);
    logic [MAX_DATA_W-1:0] mask;
    logic [MAX_DATA_W-1:0] masked;
    mask   = {MAX_DATA_W{1'b1}} >> (MAX_DATA_W - data_w / 2);
    masked = word & mask;
    return masked[MAX_DATA_W/2-1:0];
  endfunction

  // Reduce an accumulator value (already sign/zero-extended to MAX_ACC_W)
  // to a data_w-bit result. With sat_en the value is clamped to the
  // representable range first; the low data_w bits of the return value are
  // the result word in either case.
  function automatic logic [MAX_DATA_W-1:0] reduce_result(input logic signed [MAX_ACC_W-1:0] value,
                                                          input int data_w,
                                                          input bit is_signed,
                                                          input bit sat_en);
    logic signed [MAX_ACC_W-1:0] hi;
    logic signed [MAX_ACC_W-1:0] lo;
    logic signed [MAX_ACC_W-1:0] res;
    // Logical right shift of all-ones yields 2^(w)-1 for the desired w.
    hi  = '1;
    hi  = hi >> (MAX_ACC_W - data_w + (is_signed ? 1 : 0));
    lo  = is_signed ? ~hi : '0;
    res = value;
    if (sat_en) begin
      if (value > hi) begin
        res = hi;
      end else if (value < lo) begin
        res = lo;
      end
    end
    return res[MAX_DATA_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/matmul_mac.sv
`default_nettype none
// ============================================================================
// Module      : matmul_mac
// Description : Multiply-accumulate stage. Registers one operand pair per
//               cycle together with its element tags, multiplies, and
//               accumulates. On the final k of an element it presents the
//               reduced result on the write port in the same cycle.
// Ports       : clk, reset_n        clock / async active-low reset
//               in_valid/first/last operand pair tags (aligned with op_a/op_b)
//               in_addr             result address of the element
//               op_a, op_b          SRAM read data
//               wr_en/addr/data     result write port
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int SIGNED = 0,
  parameter int SAT_EN = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic              in_first,
  input  logic              in_last,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int ACC_W = 2 * DATA_W + 4;

  logic [DATA_W-1:0]          a_q;
  logic [DATA_W-1:0]          b_q;
  logic                       v_q;
  logic                       first_q;
  logic                       last_q;
  logic [ADDR_W-1:0]          addr_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    a_ext;
  logic signed [ACC_W-1:0]    b_ext;
  logic signed [ACC_W-1:0]    prod;
  logic signed [ACC_W-1:0]    sum;
  logic signed [MAX_ACC_W-1:0] sum_ext;
  logic [DATA_W-1:0]          reduced;

  generate
    if (SIGNED != 0) begin : g_signed
      assign a_ext   = ACC_W'($signed(a_q));
      assign b_ext   = ACC_W'($signed(b_q));
      assign sum_ext = MAX_ACC_W'(sum);
    end else begin : g_unsigned
      assign a_ext   = ACC_W'(a_q);
      assign b_ext   = ACC_W'(b_q);
      assign sum_ext = MAX_ACC_W'($unsigned(sum));
    end
  endgenerate

  // The product of two DATA_W operands always fits in ACC_W bits.
  assign prod    = a_ext * b_ext;
  // The accumulator restarts at k=0 by ignoring the stale value.
  assign sum     = (first_q ? '0 : acc_q) + prod;
  assign reduced = DATA_W'(reduce_result(sum_ext, DATA_W, SIGNED != 0, SAT_EN != 0));

  assign wr_en   = v_q & last_q;
  assign wr_addr = wr_en ? addr_q  : '0;
  assign wr_data = wr_en ? reduced : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      v_q     <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      acc_q   <= '0;
    end else begin
      v_q     <= in_valid;
      first_q <= in_first;
      last_q  <= in_last;
      addr_q  <= in_addr;
      if (in_valid) begin
        a_q <= op_a;
        b_q <= op_b;
      end
      if (v_q) begin
        acc_q <= sum;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/matmul_multi_engine.sv
`default_nettype none
// ============================================================================
// Module      : matmul_multi_engine
// Description : Computes R_m = I x W_m for m = 0..NUM_MATS-1 from the input
//               and weight SRAMs and writes every result to the result SRAM.
//               Headers are checked before computing; a bad header flags
//               dut_error and produces no writes. DATA_W up to 128.
// Ports       : clk, reset_n                  clock / async active-low reset
//               dut_valid, dut_ready          job handshake
//               dut_error                     last job rejected
//               dut__tb__sram_input_*         input SRAM read port
//               dut__tb__sram_weight_*        weight SRAM read port
//               dut__tb__sram_result_*        result SRAM write port
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_multi_engine
  import matmul_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 16,
  parameter int NUM_MATS = 3,
  parameter int SIGNED   = 0,
  parameter int SAT_EN   = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dut_valid,
  output logic              dut_ready,
  output logic              dut_error,
  output logic [ADDR_W-1:0] dut__tb__sram_input_read_address,
  input  logic [DATA_W-1:0] tb__dut__sram_input_read_data,
  output logic [ADDR_W-1:0] dut__tb__sram_weight_read_address,
  input  logic [DATA_W-1:0] tb__dut__sram_weight_read_data,
  output logic              dut__tb__sram_result_write_enable,
  output logic [ADDR_W-1:0] dut__tb__sram_result_write_address,
  output logic [DATA_W-1:0] dut__tb__sram_result_write_data
);

  localparam int DIM_W = DATA_W / 2;
  localparam int MAT_W = 4;

  logic [STATE_W-1:0] state;
  logic               ready_q;
  logic               error_q;
  logic [DIM_W-1:0]   dim_m, dim_k, dim_n, dim_wk;
  logic [DIM_W-1:0]   cnt_i, cnt_n, cnt_k;
  logic [MAT_W-1:0]   cnt_m;
  logic [ADDR_W-1:0]  in_addr, w_addr, row_base, mat_base, res_addr;
  logic               s1_valid, s1_first, s1_last;
  logic [ADDR_W-1:0]  s1_addr;
  logic               dims_ok, issue;
  logic               last_k, last_n, last_i, last_m, last_elem;

  assign dims_ok   = (dim_m != '0) && (dim_k != '0) && (dim_n != '0) && (dim_k == dim_wk);
  // CHECK doubles as the first issue cycle so operands start in cycle 3.
  assign issue     = ((state == ST_CHECK) && dims_ok) || (state == ST_MAC);
  assign last_k    = (cnt_k == dim_k - 1'b1);
  assign last_n    = (cnt_n == dim_n - 1'b1);
  assign last_i    = (cnt_i == dim_m - 1'b1);
  assign last_m    = (cnt_m == MAT_W'(NUM_MATS - 1));
  assign last_elem = last_k && last_n && last_i && last_m;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      ready_q  <= 1'b0;
      error_q  <= 1'b0;
      dim_m    <= '0;
      dim_k    <= '0;
      dim_n    <= '0;
      dim_wk   <= '0;
      cnt_i    <= '0;
      cnt_n    <= '0;
      cnt_k    <= '0;
      cnt_m    <= '0;
      in_addr  <= '0;
      w_addr   <= '0;
      row_base <= '0;
      mat_base <= '0;
      res_addr <= '0;
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_addr  <= '0;
    end else begin
      // Tags travel one cycle behind the address, aligned with SRAM data.
      s1_valid <= issue;
      s1_first <= issue && (cnt_k == '0);
      s1_last  <= issue && last_k;
      s1_addr  <= res_addr;

      case (state)
        ST_IDLE: begin
          if (ready_q && dut_valid) begin
            state   <= ST_HDR_ADDR;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            in_addr <= '0;
            w_addr  <= '0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_HDR_ADDR: begin
          state <= ST_HDR_LATCH;
        end
        ST_HDR_LATCH: begin
          dim_m    <= DIM_W'(hdr_hi(MAX_DATA_W'(tb__dut__sram_input_read_data), DATA_W));
          dim_k    <= DIM_W'(hdr_lo(MAX_DATA_W'(tb__dut__sram_input_read_data), DATA_W));
          dim_wk   <= DIM_W'(hdr_hi(MAX_DATA_W'(tb__dut__sram_weight_read_data), DATA_W));
          dim_n    <= DIM_W'(hdr_lo(MAX_DATA_W'(tb__dut__sram_weight_read_data), DATA_W));
          in_addr  <= ADDR_W'(1);
          w_addr   <= ADDR_W'(1);
          row_base <= ADDR_W'(1);
          mat_base <= ADDR_W'(1);
          res_addr <= '0;
          cnt_i    <= '0;
          cnt_n    <= '0;
          cnt_k    <= '0;
          cnt_m    <= '0;
          state    <= ST_CHECK;
        end
        ST_CHECK: begin
          if (!dims_ok) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            error_q <= 1'b1;
          end else begin
            state <= last_elem ? ST_DRAIN : ST_MAC;
          end
        end
        ST_MAC: begin
          if (last_elem) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Stage-1 empty means the final write is in the MAC stage now.
          if (!s1_valid) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      // Address walk in m, i, n, k order. Weights are column-major so the
      // weight pointer only rewinds when a row of I is finished.
      if (issue) begin
        if (!last_k) begin
          cnt_k   <= cnt_k + 1'b1;
          in_addr <= in_addr + 1'b1;
          w_addr  <= w_addr + 1'b1;
        end else begin
          cnt_k    <= '0;
          res_addr <= res_addr + 1'b1;
          if (!last_n) begin
            cnt_n   <= cnt_n + 1'b1;
            in_addr <= row_base;
            w_addr  <= w_addr + 1'b1;
          end else begin
            cnt_n <= '0;
            if (!last_i) begin
              cnt_i    <= cnt_i + 1'b1;
              in_addr  <= in_addr + 1'b1;
              row_base <= in_addr + 1'b1;
              w_addr   <= mat_base;
            end else begin
              cnt_i    <= '0;
              cnt_m    <= cnt_m + 1'b1;
              in_addr  <= ADDR_W'(1);
              row_base <= ADDR_W'(1);
              w_addr   <= w_addr + 1'b1;
              mat_base <= w_addr + 1'b1;
            end
          end
        end
      end
    end
  end

  matmul_mac #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .SIGNED (SIGNED),
    .SAT_EN (SAT_EN)
  ) u_mac (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (s1_valid),
    .in_first (s1_first),
    .in_last  (s1_last),
    .in_addr  (s1_addr),
    .op_a     (tb__dut__sram_input_read_data),
    .op_b     (tb__dut__sram_weight_read_data),
    .wr_en    (dut__tb__sram_result_write_enable),
    .wr_addr  (dut__tb__sram_result_write_address),
    .wr_data  (dut__tb__sram_result_write_data)
  );

  assign dut_ready                         = ready_q;
  assign dut_error                         = error_q;
  assign dut__tb__sram_input_read_address  = in_addr;
  assign dut__tb__sram_weight_read_address = w_addr;

endmodule
`default_nettype wire

// File: tb/tb_matmul_multi_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_matmul_multi_engine
// Description : Directed self-checking bench. Four engine instances:
//               0 = basic (NUM_MATS=1), 1 = multi (NUM_MATS=3),
//               2 = signed saturating, 3 = signed truncating.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_multi_engine;

  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n;
  logic [NI-1:0]  valid, ready, error, we;
  logic [15:0]    iaddr [NI];
  logic [15:0]    waddr [NI];
  logic [15:0]    raddr [NI];
  logic [31:0]    irdata [NI];
  logic [31:0]    wrdata [NI];
  logic [31:0]    wdata [NI];
  logic [31:0]    imem [NI][16];
  logic [31:0]    wmem [NI][16];

  int          cyc = 0;
  int          acc_cyc [NI];
  int          wcnt [NI];
  logic [15:0] log_addr [NI][64];
  logic [31:0] log_data [NI][64];
  int          log_cyc [NI][64];
  int          n_checks = 0;
  int          n_errors = 0;
  int          basic_exp [4] = '{58, 64, 139, 154};

  for (genvar g = 0; g < NI; g++) begin : g_dut
    matmul_multi_engine #(
      .DATA_W   (32),
      .ADDR_W   (16),
      .NUM_MATS ((g == 1) ? 3 : 1),
      .SIGNED   ((g >= 2) ? 1 : 0),
      .SAT_EN   ((g == 2) ? 1 : 0)
    ) u_dut (
      .clk                                (clk),
      .reset_n                            (reset_n),
      .dut_valid                          (valid[g]),
      .dut_ready                          (ready[g]),
      .dut_error                          (error[g]),
      .dut__tb__sram_input_read_address   (iaddr[g]),
      .tb__dut__sram_input_read_data      (irdata[g]),
      .dut__tb__sram_weight_read_address  (waddr[g]),
      .tb__dut__sram_weight_read_data     (wrdata[g]),
      .dut__tb__sram_result_write_enable  (we[g]),
      .dut__tb__sram_result_write_address (raddr[g]),
      .dut__tb__sram_result_write_data    (wdata[g])
    );
  end

  // SRAM models (1-cycle read latency), accept tracker and write logger.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < NI; g++) begin
      irdata[g] <= imem[g][iaddr[g][3:0]];
      wrdata[g] <= wmem[g][waddr[g][3:0]];
      if (valid[g] && ready[g]) acc_cyc[g] <= cyc;
      if (we[g]) begin
        log_addr[g][wcnt[g] % 64] <= raddr[g];
        log_data[g][wcnt[g] % 64] <= wdata[g];
        log_cyc[g][wcnt[g] % 64]  <= cyc;
        wcnt[g]                   <= wcnt[g] + 1;
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Caller is at a negedge; valid is held for one cycle.
  task automatic start_job(input int g);
    valid[g] = 1'b1;
    @(negedge clk);
    valid[g] = 1'b0;
  endtask

  // Returns at the first negedge with ready high; rel is the cycle number.
  task automatic wait_idle(input int g, input int limit, output int rel);
    int n = 0;
    while (!ready[g] && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!ready[g]) check_val($sformatf("idle_timeout_%0d", g), 64'(ready[g]), 64'd1);
    rel = cyc - acc_cyc[g];
  endtask

  task automatic check_wr(input string tag, input int g, input int idx,
                          input int ea, input logic [31:0] ed, input int ec);
    check_val({tag, "_addr"}, 64'(log_addr[g][idx % 64]), 64'(ea));
    check_val({tag, "_data"}, 64'(log_data[g][idx % 64]), 64'(ed));
    check_val({tag, "_cyc"},  64'(log_cyc[g][idx % 64] - acc_cyc[g]), 64'(ec));
  endtask

  task automatic load_basic();
    imem[0][0] = 32'h0002_0003;
    for (int j = 1; j <= 6; j++) imem[0][j] = 32'(j);
    wmem[0][0] = 32'h0003_0002;
    wmem[0][1] = 32'd7;  wmem[0][2] = 32'd9;  wmem[0][3] = 32'd11;
    wmem[0][4] = 32'd8;  wmem[0][5] = 32'd10; wmem[0][6] = 32'd12;
  endtask

  task automatic run_basic(input string tag);
    int base;
    int rel;
    base = wcnt[0];
    start_job(0);
    wait_idle(0, 40, rel);
    check_val({tag, "_ready_cyc"}, 64'(rel), 64'd17);
    check_val({tag, "_wr_count"}, 64'(wcnt[0] - base), 64'd4);
    for (int j = 0; j < 4; j++)
      check_wr($sformatf("%s_w%0d", tag, j), 0, base + j, j, 32'(basic_exp[j]), 7 + 3 * j);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int rel;
    int a1;
    reset_n = 1'b0;
    valid   = '0;
    load_basic();
    imem[1][0] = 32'h0001_0001; imem[1][1] = 32'd5;
    wmem[1][0] = 32'h0001_0001; wmem[1][1] = 32'd2; wmem[1][2] = 32'd3; wmem[1][3] = 32'd4;
    for (int g = 2; g < 4; g++) begin
      imem[g][0] = 32'h0001_0002; imem[g][1] = 32'h4000_0000; imem[g][2] = 32'h4000_0000;
      wmem[g][0] = 32'h0002_0001; wmem[g][1] = 32'd4;         wmem[g][2] = 32'd4;
    end

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check_val("rst_ready", 64'(ready[0]), 64'd0);
    check_val("rst_error", 64'(error[0]), 64'd0);
    check_val("rst_we",    64'(we[0]),    64'd0);
    check_val("rst_iaddr", 64'(iaddr[0]), 64'd0);
    check_val("rst_waddr", 64'(waddr[0]), 64'd0);
    check_val("rst_raddr", 64'(raddr[0]), 64'd0);
    check_val("rst_wdata", 64'(wdata[0]), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("ready_after_rst", 64'(ready), 64'hF);

    // Basic 2x3 * 3x2
    run_basic("basic");

    // Three 1x1 weight matrices
    base = wcnt[1];
    start_job(1);
    wait_idle(1, 40, rel);
    check_val("multi_ready_cyc", 64'(rel), 64'd8);
    check_val("multi_wr_count", 64'(wcnt[1] - base), 64'd3);
    check_wr("multi_w0", 1, base,     0, 32'd10, 5);
    check_wr("multi_w1", 1, base + 1, 1, 32'd15, 6);
    check_wr("multi_w2", 1, base + 2, 2, 32'd20, 7);

    // Signed overflow: saturate vs truncate
    for (int g = 2; g < 4; g++) begin
      base = wcnt[g];
      start_job(g);
      wait_idle(g, 40, rel);
      check_val($sformatf("ovf%0d_ready_cyc", g), 64'(rel), 64'd7);
      check_val($sformatf("ovf%0d_wr_count", g), 64'(wcnt[g] - base), 64'd1);
      check_wr($sformatf("ovf%0d", g), g, base, 0, (g == 2) ? 32'h7FFF_FFFF : 32'h0000_0000, 6);
    end

    // Dimension fault: input K=3, weight K=4
    imem[0][0] = 32'h0002_0003;
    wmem[0][0] = 32'h0004_0002;
    base = wcnt[0];
    start_job(0);
    wait_idle(0, 40, rel);
    check_val("fault_ready_cyc", 64'(rel), 64'd4);
    check_val("fault_error", 64'(error[0]), 64'd1);
    repeat (3) @(negedge clk);
    check_val("fault_no_writes", 64'(wcnt[0] - base), 64'd0);

    // Next job clears the error; then reset in the middle of it
    load_basic();
    base = wcnt[0];
    start_job(0);
    check_val("error_cleared", 64'(error[0]), 64'd0);
    repeat (9) @(negedge clk);
    check_val("pre_reset_we",    64'(we[0]),    64'd1);
    check_val("pre_reset_wdata", 64'(wdata[0]), 64'd64);
    reset_n = 1'b0;
    #1;
    check_val("midrst_we",    64'(we[0]),    64'd0);
    check_val("midrst_ready", 64'(ready[0]), 64'd0);
    check_val("midrst_wdata", 64'(wdata[0]), 64'd0);
    check_val("midrst_iaddr", 64'(iaddr[0]), 64'd0);
    repeat (3) @(negedge clk);
    check_val("midrst_wr_count", 64'(wcnt[0] - base), 64'd1);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("midrst_ready_back", 64'(ready[0]), 64'd1);
    run_basic("rerun");

    // Back-to-back, with a valid pulse while busy
    base = wcnt[0];
    start_job(0);
    repeat (4) @(negedge clk);
    valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    wait_idle(0, 40, rel);
    check_val("b2b1_ready_cyc", 64'(rel), 64'd17);
    for (int j = 0; j < 4; j++)
      check_wr($sformatf("b2b1_w%0d", j), 0, base + j, j, 32'(basic_exp[j]), 7 + 3 * j);
    a1 = acc_cyc[0];
    start_job(0);
    check_val("b2b2_accept_gap", 64'(acc_cyc[0] - a1), 64'd17);
    wait_idle(0, 40, rel);
    check_val("b2b2_ready_cyc", 64'(rel), 64'd17);
    check_val("b2b_wr_count", 64'(wcnt[0] - base), 64'd8);
    for (int j = 0; j < 4; j++)
      check_wr($sformatf("b2b2_w%0d", j), 0, base + 4 + j, j, 32'(basic_exp[j]), 7 + 3 * j);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
